// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, memory-wait freeze,
// EX operand forwarding, plus stall/flush statistics and a sticky memory timeout.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        rs1_used,
  input  logic        rs2_used,
  input  logic [4:0]  rs1_EX,
  input  logic [4:0]  rs2_EX,
  input  logic [4:0]  rd_EX,
  input  logic        RegWrite_EX,
  input  logic        DatatoReg_EX,
  input  logic [4:0]  rd_MEM,
  input  logic        RegWrite_MEM,
  input  logic        DatatoReg_MEM,
  input  logic [4:0]  rd_WB,
  input  logic        RegWrite_WB,
  input  logic        branch_taken_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ack,
  output logic        PC_EN,
  output logic        IFID_EN,
  output logic        IFID_flush,
  output logic        IDEX_EN,
  output logic        IDEX_flush,
  output logic        EXMEM_EN,
  output logic        MEMWB_EN,
  output logic [1:0]  fwd_A,
  output logic [1:0]  fwd_B,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_err
);

  typedef enum logic {RUN = 1'b0, MWAIT = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [7:0]  wait_cnt_reg;
  logic [31:0] stall_cnt_reg;
  logic [15:0] flush_cnt_reg;
  logic        mem_err_reg;

  logic ms, br, lu;

  // Hazard conditions; memory stall dominates everything else.
  assign ms = mem_req_MEM & ~mem_ack;
  assign br = branch_taken_EX;
  assign lu = DatatoReg_EX & RegWrite_EX & (rd_EX != 5'd0) &
              ((rs1_used & (rs1_ID == rd_EX)) | (rs2_used & (rs2_ID == rd_EX)));

  // Forwarding: one identical selector per EX operand. Loads in MEM have no
  // data yet, so only ALU results are taken from EX/MEM.
  logic [4:0] rs_ex [2];
  assign rs_ex[0] = rs1_EX;
  assign rs_ex[1] = rs2_EX;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [1:0] sel;
      // Pick the youngest in-flight producer of this operand.
      always_comb begin
        sel = 2'b00;
        if (RegWrite_MEM && !DatatoReg_MEM && (rd_MEM != 5'd0) && (rd_MEM == rs_ex[gi]))
          sel = 2'b01;
        else if (RegWrite_WB && (rd_WB != 5'd0) && (rd_WB == rs_ex[gi]))
          sel = 2'b10;
      end
    end
  endgenerate

  assign fwd_A = g_fwd[0].sel;
  assign fwd_B = g_fwd[1].sel;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  // Next state: enter MWAIT on a stalled access, leave once it completes or drops.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (ms) state_next = MWAIT;
      MWAIT:   if (mem_ack || !mem_req_MEM) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  // Pipeline register controls, strictly prioritised freeze > flush > bubble.
  always_comb begin
    PC_EN      = 1'b1;
    IFID_EN    = 1'b1;
    IFID_flush = 1'b0;
    IDEX_EN    = 1'b1;
    IDEX_flush = 1'b0;
    EXMEM_EN   = 1'b1;
    MEMWB_EN   = 1'b1;
    if (ms) begin
      PC_EN    = 1'b0;
      IFID_EN  = 1'b0;
      IDEX_EN  = 1'b0;
      EXMEM_EN = 1'b0;
      MEMWB_EN = 1'b0;
    end else if (br) begin
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (lu) begin
      PC_EN      = 1'b0;
      IFID_EN    = 1'b0;
      IDEX_flush = 1'b1;
    end
  end

  // Wait timer, timeout flag and statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg  <= 8'd0;
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 16'd0;
      mem_err_reg   <= 1'b0;
    end else begin
      if (state_reg == MWAIT && state_next == MWAIT) begin
        if (ms && wait_cnt_reg != 8'hFF) wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end else begin
        wait_cnt_reg <= 8'd0;
      end
      if (state_reg == MWAIT && ms && wait_cnt_reg == 8'hFE) mem_err_reg <= 1'b1;
      if ((ms || (lu && !br)) && stall_cnt_reg != 32'hFFFF_FFFF)
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      if (br && !ms) flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
  assign mem_err   = mem_err_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, forwarding, branch, memory wait, timeout.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, rd_MEM, rd_WB;
  logic        rs1_used, rs2_used, RegWrite_EX, DatatoReg_EX;
  logic        RegWrite_MEM, DatatoReg_MEM, RegWrite_WB;
  logic        branch_taken_EX, mem_req_MEM, mem_ack;
  logic        PC_EN, IFID_EN, IFID_flush, IDEX_EN, IDEX_flush, EXMEM_EN, MEMWB_EN;
  logic [1:0]  fwd_A, fwd_B;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
  logic        mem_err;

  int passed = 0;
  int total  = 0;

  // Control vector order: PC_EN IFID_EN IFID_flush IDEX_EN IDEX_flush EXMEM_EN MEMWB_EN
  localparam logic [6:0] C_NORM = 7'b1101011;
  localparam logic [6:0] C_BR   = 7'b1111111;
  localparam logic [6:0] C_LU   = 7'b0001111;
  localparam logic [6:0] C_MS   = 7'b0000000;

  logic [6:0] ctrl;
  assign ctrl = {PC_EN, IFID_EN, IFID_flush, IDEX_EN, IDEX_flush, EXMEM_EN, MEMWB_EN};

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
    .rd_EX(rd_EX), .RegWrite_EX(RegWrite_EX), .DatatoReg_EX(DatatoReg_EX),
    .rd_MEM(rd_MEM), .RegWrite_MEM(RegWrite_MEM), .DatatoReg_MEM(DatatoReg_MEM),
    .rd_WB(rd_WB), .RegWrite_WB(RegWrite_WB),
    .branch_taken_EX(branch_taken_EX), .mem_req_MEM(mem_req_MEM), .mem_ack(mem_ack),
    .PC_EN(PC_EN), .IFID_EN(IFID_EN), .IFID_flush(IFID_flush), .IDEX_EN(IDEX_EN),
    .IDEX_flush(IDEX_flush), .EXMEM_EN(EXMEM_EN), .MEMWB_EN(MEMWB_EN),
    .fwd_A(fwd_A), .fwd_B(fwd_B), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_err(mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %s: observed %0h expected %0h", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rs1_ID = 0; rs2_ID = 0; rs1_used = 0; rs2_used = 0;
    rs1_EX = 0; rs2_EX = 0;
    rd_EX = 0; RegWrite_EX = 0; DatatoReg_EX = 0;
    rd_MEM = 0; RegWrite_MEM = 0; DatatoReg_MEM = 0;
    rd_WB = 0; RegWrite_WB = 0;
    branch_taken_EX = 0; mem_req_MEM = 0; mem_ack = 0;
  endtask

  // Advance one clock edge and land mid-low phase for checking/driving.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #12;
    chk("rst_ctrl",  {25'd0, ctrl}, {25'd0, C_NORM});
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", {16'd0, flush_cnt}, 32'd0);
    chk("rst_err",   {31'd0, mem_err}, 32'd0);
    chk("rst_fwd",   {28'd0, fwd_A, fwd_B}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;

    // Load x5 in EX, add in ID reads x5 -> one bubble
    rd_EX = 5; RegWrite_EX = 1; DatatoReg_EX = 1; rs1_ID = 5; rs1_used = 1;
    #1 chk("lu_ctrl", {25'd0, ctrl}, {25'd0, C_LU});
    tick();
    chk("lu_stall", stall_cnt, 32'd1);
    // Load now in MEM, bubble in EX: nothing forwarded from a load in MEM
    clr(); rs1_ID = 5; rs1_used = 1;
    rd_MEM = 5; RegWrite_MEM = 1; DatatoReg_MEM = 1; rs1_EX = 5;
    #1 chk("lu_bubble_ctrl", {25'd0, ctrl}, {25'd0, C_NORM});
    chk("lu_mem_load_fwdA", {30'd0, fwd_A}, 32'd0);
    tick();
    chk("lu_bubble_stall", stall_cnt, 32'd1);
    // Load in WB, add in EX -> write-back forwarding
    clr(); rd_WB = 5; RegWrite_WB = 1; rs1_EX = 5;
    #1 chk("lu_wb_fwdA", {30'd0, fwd_A}, 32'd2);

    // Unused rs2 or destination x0 do not create a load-use hazard
    clr(); rd_EX = 6; RegWrite_EX = 1; DatatoReg_EX = 1; rs2_ID = 6; rs2_used = 0;
    #1 chk("lu_unused_ctrl", {25'd0, ctrl}, {25'd0, C_NORM});
    rs2_used = 1;
    #1 chk("lu_rs2_ctrl", {25'd0, ctrl}, {25'd0, C_LU});
    rd_EX = 0; rs2_ID = 0;
    #1 chk("lu_x0_ctrl", {25'd0, ctrl}, {25'd0, C_NORM});

    // MEM beats WB; x0 never forwarded; WB-only match
    clr(); rd_MEM = 7; RegWrite_MEM = 1; rd_WB = 7; RegWrite_WB = 1; rs2_EX = 7; rs1_EX = 7;
    #1 chk("fwd_mem_B", {30'd0, fwd_B}, 32'd1);
    chk("fwd_mem_A", {30'd0, fwd_A}, 32'd1);
    rd_MEM = 0; rd_WB = 0; rs2_EX = 0;
    #1 chk("fwd_x0_B", {30'd0, fwd_B}, 32'd0);
    rd_MEM = 3; rd_WB = 7; rs2_EX = 7;
    #1 chk("fwd_wb_B", {30'd0, fwd_B}, 32'd2);
    RegWrite_WB = 0;
    #1 chk("fwd_nowr_B", {30'd0, fwd_B}, 32'd0);
    tick();

    // Branch together with load-use: branch wins
    clr(); rd_EX = 9; RegWrite_EX = 1; DatatoReg_EX = 1; rs1_ID = 9; rs1_used = 1;
    branch_taken_EX = 1;
    #1 chk("br_lu_ctrl", {25'd0, ctrl}, {25'd0, C_BR});
    tick();
    chk("br_flush", {16'd0, flush_cnt}, 32'd1);
    chk("br_stall", stall_cnt, 32'd1);

    // Memory stall 3 cycles (branch during freeze is ignored), then ack
    clr(); mem_req_MEM = 1; branch_taken_EX = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("ms_ctrl%0d", i), {25'd0, ctrl}, {25'd0, C_MS});
      tick();
      branch_taken_EX = 0;
    end
    chk("ms_stall", stall_cnt, 32'd4);
    chk("ms_flush", {16'd0, flush_cnt}, 32'd1);
    mem_ack = 1;
    #1 chk("ms_ack_ctrl", {25'd0, ctrl}, {25'd0, C_NORM});
    tick();
    chk("ms_ack_stall", stall_cnt, 32'd4);
    clr();
    #1 chk("ms_after_ctrl", {25'd0, ctrl}, {25'd0, C_NORM});
    tick();

    // Timeout: error after 256 stalled edges (1 RUN + 255 MWAIT)
    mem_req_MEM = 1;
    for (int i = 0; i < 255; i++) tick();
    chk("to_err_pre", {31'd0, mem_err}, 32'd0);
    tick();
    chk("to_err_set", {31'd0, mem_err}, 32'd1);
    for (int i = 0; i < 44; i++) tick();
    chk("to_err_hold", {31'd0, mem_err}, 32'd1);
    chk("to_ctrl", {25'd0, ctrl}, {25'd0, C_MS});
    chk("to_stall", stall_cnt, 32'd304);

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1 chk("rst2_err", {31'd0, mem_err}, 32'd0);
    chk("rst2_stall", stall_cnt, 32'd0);
    chk("rst2_flush", {16'd0, flush_cnt}, 32'd0);
    chk("rst2_ctrl", {25'd0, ctrl}, {25'd0, C_MS});
    @(negedge clk); rst = 1'b0;

    // Back in RUN with cleared timer: 255 stalled edges do not trip the error
    for (int i = 0; i < 255; i++) tick();
    chk("rst2_err_pre", {31'd0, mem_err}, 32'd0);
    tick();
    chk("rst2_err_set", {31'd0, mem_err}, 32'd1);
    chk("rst2_stall_cnt", stall_cnt, 32'd256);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 rs1_ID, rs2_ID  in  5 each  source register addresses of the instruction in ID.
REQ-004 rs1_used, rs2_used  in  1 each  ID instruction actually reads rs1/rs2.
REQ-005 rs1_EX, rs2_EX  in  5 each  source addresses held in the ID/EX register.
REQ-006 rd_EX, RegWrite_EX, DatatoReg_EX  in  5/1/1  destination, write enable and load flag of the EX instruction.
REQ-007 rd_MEM, RegWrite_MEM, DatatoReg_MEM  in  5/1/1  same fields for the MEM instruction.
REQ-008 rd_WB, RegWrite_WB  in  5/1  destination and write enable of the WB instruction.
REQ-009 branch_taken_EX  in  1  EX-resolved redirect (taken branch or jump).
REQ-010 mem_req_MEM, mem_ack  in  1 each  MEM-stage data access valid; memory completion.
REQ-011 PC_EN, IFID_EN, IFID_flush, IDEX_EN, IDEX_flush, EXMEM_EN, MEMWB_EN  out  1 each  pipeline register controls.
REQ-012 fwd_A, fwd_B  out  2 each  EX operand select: 00 register file, 01 EX/MEM ALU result, 10 MEM/WB write-back data.
REQ-013 stall_cnt  out  32  stall-cycle counter; flush_cnt  out  16  branch-flush counter.
REQ-014 mem_err  out  1  sticky memory-timeout flag.

Function
REQ-015 Conditions (combinational): MS = mem_req_MEM & ~mem_ack; BR = branch_taken_EX; LU = DatatoReg_EX & RegWrite_EX & rd_EX!=0 & ((rs1_used & rs1_ID==rd_EX) | (rs2_used & rs2_ID==rd_EX)).
REQ-016 Priority MS > BR > LU > normal; exactly one case drives the controls each cycle.
REQ-017 MS: all *_EN = 0, all flushes = 0 (full freeze).
REQ-018 BR (no MS): all EN = 1, IFID_flush = 1, IDEX_flush = 1; BR wins over a simultaneous LU.
REQ-019 LU (no MS, no BR): PC_EN = 0, IFID_EN = 0, IDEX_EN = 1, IDEX_flush = 1, EXMEM_EN = MEMWB_EN = 1; exactly one bubble per load-use pair.
REQ-020 Normal: all EN = 1, all flushes = 0.
REQ-021 fwd_A = 01 if RegWrite_MEM & ~DatatoReg_MEM & rd_MEM!=0 & rd_MEM==rs1_EX; else 10 if RegWrite_WB & rd_WB!=0 & rd_WB==rs1_EX; else 00; fwd_B identical using rs2_EX; MEM match beats WB match.
REQ-022 Forwarding outputs are purely combinational and independent of the FSM state.
REQ-023 FSM states RUN, MWAIT; RUN -> MWAIT when MS; MWAIT -> RUN when mem_ack or ~mem_req_MEM; otherwise hold.
REQ-024 wait_cnt (8-bit, internal): 0 in RUN; +1 per MWAIT cycle with MS, saturates at 255; cleared to 0 on MWAIT -> RUN.
REQ-025 mem_err set on the edge where wait_cnt becomes 255; stays 1 until rst; the freeze continues regardless.
REQ-026 stall_cnt +1 on every edge where MS or (LU & ~BR) holds; saturates at 32'hFFFFFFFF.
REQ-027 flush_cnt +1 on every edge where BR & ~MS holds; wraps 16'hFFFF -> 0.
REQ-028 A cycle with mem_ack = 1 in MWAIT uses normal/BR/LU controls that same cycle (no extra freeze cycle).

Reset
REQ-029 rst = 1 asynchronously forces state RUN, wait_cnt = 0, stall_cnt = 0, flush_cnt = 0, mem_err = 0.
REQ-030 Combinational outputs follow REQ-015..021 during reset; rst asserted mid-MWAIT returns to RUN at once without setting mem_err.

Verification
REQ-031 Load x5 in EX (DatatoReg_EX=1, rd_EX=5), ID add reads rs1=5 -> one cycle PC_EN=0, IFID_EN=0, IDEX_flush=1; stall_cnt 0->1; next cycle fwd_A=10.
REQ-032 ALU rd_MEM=7 and rd_WB=7 both writing, rs2_EX=7 -> fwd_B=01; rd_MEM=0 with rs2_EX=0 -> fwd_B=00.
REQ-033 BR and LU asserted together -> IFID_flush=IDEX_flush=1, PC_EN=1, flush_cnt +1, stall_cnt unchanged.
REQ-034 mem_req_MEM=1, mem_ack low 3 cycles then high -> all EN=0 for 3 cycles, state MWAIT, stall_cnt +3, normal controls in the ack cycle, RUN afterwards.
REQ-035 mem_ack held low 300 cycles -> mem_err=1 once wait_cnt reaches 255, freeze persists; rst pulse -> mem_err=0, counters 0, state RUN.
